// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding
// and the default baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam int unsigned UART_CLKDIV_DEFAULT = 434;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time down-counter: reloads CLKDIV-1 on load, decrements to zero and
// holds there; tick marks the final cycle of the current bit.
module uart_baud_cnt #(
    parameter int unsigned CLKDIV = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load,
    output logic tick
);

    localparam int unsigned BW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        if (load) begin
            bcnt_d = BW'(CLKDIV - 1);
        end else if (bcnt_q != '0) begin
            bcnt_d = bcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign tick = (bcnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a synchronous FIFO; frames are start/data(LSB
// first)/stop. Define FIFO_UART_TX_PARITY_EN to add an even-parity bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned CLKDIV = UART_CLKDIV_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_out,
    output logic              fifo_pop,
    input  logic              cts_ni,
    output logic              txd,
    output logic              busy
);

    localparam int unsigned IW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    uart_tx_state_t    state_q, state_d;
    logic [DWIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     bidx_q, bidx_d;
    logic              txd_q, txd_d;
    logic              load;
    logic              tick;
    logic              launch;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    uart_baud_cnt #(
        .CLKDIV(CLKDIV)
    ) u_baud (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .load  (load),
        .tick  (tick)
    );

    // A new frame may start from IDLE or in the very last STOP cycle.
    assign launch = !fifo_empty && !cts_ni &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bidx_d  = bidx_q;
        load    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (launch) begin
            state_d = ST_START;
            shreg_d = fifo_out;
            load    = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d   = ^fifo_out;
`endif
        end else begin
            case (state_q)
                ST_START: begin
                    if (tick) begin
                        state_d = ST_DATA;
                        bidx_d  = IW'(DWIDTH - 1);
                        load    = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        load = 1'b1;
                        if (bidx_q == '0) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bidx_d  = bidx_q - 1'b1;
                            shreg_d = shreg_q >> 1;
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state_d = ST_STOP;
                        load    = 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Line level is decoded from the next state so txd can be registered.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bidx_q  <= '0;
            txd_q   <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bidx_q  <= bidx_d;
            txd_q   <= txd_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign fifo_pop = launch && rst_ni;
    assign txd      = txd_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (DWIDTH=8, CLKDIV=4) with a small FIFO model.
module tb_fifo_uart_tx;

    localparam int CLKDIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CLKDIV;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cts_ni = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_out;
    logic       fifo_pop;
    logic       txd;
    logic       busy;

    logic [7:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_out   = mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (fifo_pop) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    fifo_uart_tx #(
        .DWIDTH(8),
        .CLKDIV(CLKDIV)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .fifo_empty(fifo_empty),
        .fifo_out  (fifo_out),
        .fifo_pop  (fifo_pop),
        .cts_ni    (cts_ni),
        .txd       (txd),
        .busy      (busy)
    );

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Expected line level in cycle i of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        int b;
        b = i / CLKDIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
            total++; if (fifo_pop !== 1'b0) $display("FAIL reset_pop got %b want 0", fifo_pop); else passed++;
        end
        rst_ni = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy); else passed++;
        total++; if (txd !== 1'b1) $display("FAIL post_reset_txd got %b want 1", txd); else passed++;
    endtask

    task automatic test_single_word();
        int p0;
        @(negedge clk);
        p0 = pop_cnt;
        push(8'hA5);
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL single_pop got %b want 1", fifo_pop); else passed++;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            total++; if (txd !== frame_bit(8'hA5, i)) $display("FAIL single_txd cyc %0d got %b want %b", i, txd, frame_bit(8'hA5, i)); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL single_busy cyc %0d got %b want 1", i, busy); else passed++;
            total++; if (fifo_pop !== 1'b0) $display("FAIL single_nopop cyc %0d got %b want 0", i, fifo_pop); else passed++;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL single_end_busy got %b want 0", busy); else passed++;
        total++; if (txd !== 1'b1) $display("FAIL single_end_txd got %b want 1", txd); else passed++;
        total++; if (pop_cnt - p0 !== 1) $display("FAIL single_popcnt got %0d want 1", pop_cnt - p0); else passed++;
    endtask

    task automatic test_back_to_back();
        int p0;
        logic [7:0] d;
        logic exp_pop;
        @(negedge clk);
        p0 = pop_cnt;
        push(8'h00);
        push(8'hFF);
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL b2b_pop1 got %b want 1", fifo_pop); else passed++;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            @(negedge clk);
            d = (i < FRAME_CYC) ? 8'h00 : 8'hFF;
            exp_pop = (i == FRAME_CYC - 1);
            total++; if (txd !== frame_bit(d, i % FRAME_CYC)) $display("FAIL b2b_txd cyc %0d got %b want %b", i, txd, frame_bit(d, i % FRAME_CYC)); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL b2b_busy cyc %0d got %b want 1", i, busy); else passed++;
            total++; if (fifo_pop !== exp_pop) $display("FAIL b2b_pop cyc %0d got %b want %b", i, fifo_pop, exp_pop); else passed++;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL b2b_end_busy got %b want 0", busy); else passed++;
        total++; if (pop_cnt - p0 !== 2) $display("FAIL b2b_popcnt got %0d want 2", pop_cnt - p0); else passed++;
    endtask

    task automatic test_flow_control();
        int p0;
        @(negedge clk);
        p0 = pop_cnt;
        cts_ni = 1'b1;
        push(8'h3C);
        for (int k = 0; k < 20; k++) begin
            #1;
            total++; if (fifo_pop !== 1'b0) $display("FAIL cts_hold_pop cyc %0d got %b want 0", k, fifo_pop); else passed++;
            total++; if (txd !== 1'b1) $display("FAIL cts_hold_txd cyc %0d got %b want 1", k, txd); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL cts_hold_busy cyc %0d got %b want 0", k, busy); else passed++;
            @(negedge clk);
        end
        cts_ni = 1'b0;
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL cts_release_pop got %b want 1", fifo_pop); else passed++;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            total++; if (txd !== frame_bit(8'h3C, i)) $display("FAIL cts_txd cyc %0d got %b want %b", i, txd, frame_bit(8'h3C, i)); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL cts_busy cyc %0d got %b want 1", i, busy); else passed++;
            if (i == 8) cts_ni = 1'b1;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL cts_end_busy got %b want 0", busy); else passed++;
        total++; if (pop_cnt - p0 !== 1) $display("FAIL cts_popcnt got %0d want 1", pop_cnt - p0); else passed++;
        cts_ni = 1'b0;
    endtask

    task automatic test_empty();
        int p0;
        p0 = pop_cnt;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            total++; if (fifo_pop !== 1'b0) $display("FAIL empty_pop cyc %0d got %b want 0", k, fifo_pop); else passed++;
            total++; if (txd !== 1'b1) $display("FAIL empty_txd cyc %0d got %b want 1", k, txd); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL empty_busy cyc %0d got %b want 0", k, busy); else passed++;
        end
        total++; if (pop_cnt !== p0) $display("FAIL empty_popcnt got %0d want %0d", pop_cnt, p0); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        @(negedge clk);
        p0 = pop_cnt;
        push(8'h5A);
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL rst_mid_pop got %b want 1", fifo_pop); else passed++;
        // Cycles 16..19 carry data bit 3; reset lands in the middle of it.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            total++; if (txd !== frame_bit(8'h5A, i)) $display("FAIL rst_mid_txd cyc %0d got %b want %b", i, txd, frame_bit(8'h5A, i)); else passed++;
        end
        rst_ni = 1'b0;
        push(8'h81);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (txd !== 1'b1) $display("FAIL rst_mid_txd_r cyc %0d got %b want 1", k, txd); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy_r cyc %0d got %b want 0", k, busy); else passed++;
            total++; if (fifo_pop !== 1'b0) $display("FAIL rst_mid_pop_r cyc %0d got %b want 0", k, fifo_pop); else passed++;
        end
        total++; if (pop_cnt - p0 !== 1) $display("FAIL rst_mid_popcnt_r got %0d want 1", pop_cnt - p0); else passed++;
        rst_ni = 1'b1;
        #1;
        total++; if (fifo_pop !== 1'b1) $display("FAIL rst_rel_pop got %b want 1", fifo_pop); else passed++;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            total++; if (txd !== frame_bit(8'h81, i)) $display("FAIL rst_rel_txd cyc %0d got %b want %b", i, txd, frame_bit(8'h81, i)); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL rst_rel_busy cyc %0d got %b want 1", i, busy); else passed++;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL rst_rel_end_busy got %b want 0", busy); else passed++;
        total++; if (pop_cnt - p0 !== 2) $display("FAIL rst_rel_popcnt got %0d want 2", pop_cnt - p0); else passed++;
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       pbits [2];
        words[0] = 8'hA5; pbits[0] = 1'b0;
        words[1] = 8'h07; pbits[1] = 1'b1;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            push(words[w]);
            #1;
            total++; if (fifo_pop !== 1'b1) $display("FAIL par_pop w%0d got %b want 1", w, fifo_pop); else passed++;
            for (int i = 0; i < 44; i++) begin
                @(negedge clk);
                total++; if (txd !== frame_bit(words[w], i)) $display("FAIL par_txd w%0d cyc %0d got %b want %b", w, i, txd, frame_bit(words[w], i)); else passed++;
                total++; if (busy !== 1'b1) $display("FAIL par_busy w%0d cyc %0d got %b want 1", w, i, busy); else passed++;
                if (i == 37) begin
                    total++; if (txd !== pbits[w]) $display("FAIL par_bit w%0d got %b want %b", w, txd, pbits[w]); else passed++;
                end
            end
            @(negedge clk);
            total++; if (busy !== 1'b0) $display("FAIL par_end_busy w%0d got %b want 0", w, busy); else passed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_flow_control();
        test_empty();
        test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
